mac_row_feeder: RTL and testbench
=================================

Name: mac_row_feeder

Overview:
- West-edge driver for one row of the MAC tile array; the transmitter side of the tile's in_w/inst_w interface.
- Sequences a full pass per start: kernel-weight load (inst 01), guard gap, activation execute stream (inst 10), then pipeline flush.
- Handles both precision modes: 4b act/4b wgt (one weight per column) and 2b act/4b wgt (two weights per column, lane 0 then lane 1).
- Sits between the weight/activation SRAM readers and column 0 of the row.

Parameters:
- bw, 4: weight/activation width; in_w width.
- col, 8: number of tiles (columns) in the row.
- cnt_bw, 10: width of activation count and internal counters.
- gap, 2: idle cycles (inst_w=00) inserted between the last weight and the first activation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE
- mode_2b  in  1  1: 2b act/4b wgt; 0: 4b/4b; latched on accepted start
- num_act  in  cnt_bw  activations to stream this pass; latched on accepted start
- wgt_data  in  bw  weight word
- wgt_valid  in  1  wgt_data valid
- wgt_ready  out  1  feeder accepts a weight this cycle
- act_data  in  bw  activation word
- act_valid  in  1  act_data valid
- act_ready  out  1  feeder accepts an activation this cycle
- in_w  out  bw  data to tile column 0 (registered)
- inst_w  out  2  {execute, kernel_load} to tile column 0 (registered)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a pass completes

Behaviour:
- Reset: state=IDLE; in_w=0, inst_w=00, busy=0, done=0, wgt_ready=0, act_ready=0; all counters=0. Reset mid-pass aborts immediately; no done pulse.
- States: IDLE, LOAD, GAP, EXEC, FLUSH.
- IDLE: start=1 latches mode_2b and num_act, clears counters, goes to LOAD. start while busy is ignored.
- LOAD: target = col (mode 0) or 2*col (mode 1). wgt_ready=1 while wcnt<target. On wgt_valid&wgt_ready: next cycle in_w=wgt_data, inst_w=01, wcnt+1. Without a handshake: inst_w=00 and in_w holds its last value. Bubbles are legal and must not create a load.
- Word ordering: mode 0, word k targets column k. Mode 1, word k targets column k/2, lane k%2 (wgt0 first, then wgt1).
- LOAD exits to GAP in the cycle after the last accepted word; wgt_ready=0 from that point.
- GAP: exactly gap cycles of inst_w=00, then EXEC. If num_act=0, go to FLUSH instead.
- EXEC: act_ready=1 while acnt<num_act. On handshake: next cycle inst_w=10, acnt+1.
  - Mode 0: in_w=act_data.
  - Mode 1: in_w={(bw-2)'b0, act_data[1:0]}; act_data upper bits are ignored.
  - Bubble: inst_w=00, in_w holds.
  - After the last accepted activation, go to FLUSH.
- FLUSH: inst_w=00 for col+1 cycles so the last activation clears the row. Then done=1 for one cycle, busy=0, state=IDLE.
- Latency: 1 cycle from handshake to in_w/inst_w. Throughput is one word per cycle in LOAD and EXEC.
- Outputs: inst_w is never 11. wgt_ready and act_ready are never high together, and both are 0 outside LOAD/EXEC. Both are combinational from state and counters only, never from the valid inputs.
- Counter widths: wcnt holds up to 2*col. acnt compares at full cnt_bw width; num_act = 2^cnt_bw - 1 must work with no wrap.
- mode_2b and num_act changes during a pass have no effect until the next start.

Test Plan:
- Mode 0, col=8, 8 back-to-back weights 1..8, num_act=4, acts 9..12 -> inst_w 01 for 8 consecutive cycles (in_w 1..8), then 2 cycles of 00, then 10 for 4 cycles (in_w 9..12), then 9 cycles of 00, then done pulse; busy falls with done.
- Mode 1, col=8 -> exactly 16 weight handshakes with inst_w=01. act_data=4'b1110 -> in_w=4'b0010 with inst_w=10.
- wgt_valid toggling 1,0,1,0 -> inst_w alternates 01/00 and in_w holds during bubbles. Load count stays 8 (mode 0) regardless of the bubbles.
- num_act=0 -> after GAP go directly to FLUSH; zero cycles of inst_w=10; done asserts col+1 cycles after GAP ends.
- start pulsed during EXEC -> ignored, pass completes normally. Reset asserted during LOAD -> next cycle inst_w=00, busy=0, ready signals 0, no done pulse.
- Random valid gaps, 1000 passes -> scoreboard confirms the count of inst_w=01 cycles equals col×(1+mode_2b), the count of inst_w=10 cycles equals num_act, and inst_w is never 11.

Source files
------------

// File: rtl/mac_row_feeder.sv
// West-edge feeder for one MAC row: weight load, guard gap,
// activation execute stream, then pipeline flush.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             begin a pass (honoured only in IDLE)
//   mode_2b, num_act  pass configuration, latched on start
//   wgt_*             weight stream in (valid/ready)
//   act_*             activation stream in (valid/ready)
//   in_w, inst_w      registered data/instruction to column 0
//   busy, done        status; done pulses once per finished pass
module mac_row_feeder #(
    parameter int bw     = 4,
    parameter int col    = 8,
    parameter int cnt_bw = 10,
    parameter int gap    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_2b,
    input  logic [cnt_bw-1:0] num_act,
    input  logic [bw-1:0]     wgt_data,
    input  logic              wgt_valid,
    output logic              wgt_ready,
    input  logic [bw-1:0]     act_data,
    input  logic              act_valid,
    output logic              act_ready,
    output logic [bw-1:0]     in_w,
    output logic [1:0]        inst_w,
    output logic              busy,
    output logic              done
);

    localparam int WW = $clog2(2 * col + 1);
    localparam int TW = $clog2(col + gap + 1);

    localparam logic [1:0] I_NOP  = 2'b00;
    localparam logic [1:0] I_LOAD = 2'b01;
    localparam logic [1:0] I_EXEC = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        EXEC,
        FLUSH
    } state_t;

    state_t            state, state_n;
    logic              mode_q, mode_n;
    logic [cnt_bw-1:0] num_q, num_n;
    logic [WW-1:0]     wcnt, wcnt_n;
    logic [cnt_bw-1:0] acnt, acnt_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [bw-1:0]     in_w_n;
    logic [1:0]        inst_w_n;
    logic              done_n;

    logic [WW-1:0]     wtarget;
    logic              wgt_hs;
    logic              act_hs;

    assign wtarget   = mode_q ? WW'(2 * col) : WW'(col);
    assign wgt_ready = (state == LOAD) && (wcnt < wtarget);
    assign act_ready = (state == EXEC) && (acnt < num_q);
    assign busy      = (state != IDLE);
    assign wgt_hs    = wgt_valid && wgt_ready;
    assign act_hs    = act_valid && act_ready;

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        num_n    = num_q;
        wcnt_n   = wcnt;
        acnt_n   = acnt;
        tcnt_n   = tcnt;
        in_w_n   = in_w;
        inst_w_n = I_NOP;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mode_n  = mode_2b;
                    num_n   = num_act;
                    wcnt_n  = '0;
                    acnt_n  = '0;
                    tcnt_n  = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (wgt_hs) begin
                    in_w_n   = wgt_data;
                    inst_w_n = I_LOAD;
                    wcnt_n   = wcnt + WW'(1);
                    if (wcnt == wtarget - WW'(1)) begin
                        tcnt_n  = '0;
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (tcnt == TW'(gap - 1)) begin
                    tcnt_n  = '0;
                    state_n = (num_q == '0) ? FLUSH : EXEC;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            EXEC: begin
                if (act_hs) begin
                    in_w_n   = mode_q
                             ? {{(bw-2){1'b0}}, act_data[1:0]}
                             : act_data;
                    inst_w_n = I_EXEC;
                    acnt_n   = acnt + cnt_bw'(1);
                    if (acnt + cnt_bw'(1) == num_q) begin
                        tcnt_n  = '0;
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Count idle cycles actually seen on the row; the
                // first FLUSH cycle may still carry the last activation.
                if (inst_w == I_NOP) begin
                    if (tcnt == TW'(col)) begin
                        tcnt_n  = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tcnt_n = tcnt + TW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            num_q  <= '0;
            wcnt   <= '0;
            acnt   <= '0;
            tcnt   <= '0;
            in_w   <= '0;
            inst_w <= I_NOP;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            num_q  <= num_n;
            wcnt   <= wcnt_n;
            acnt   <= acnt_n;
            tcnt   <= tcnt_n;
            in_w   <= in_w_n;
            inst_w <= inst_w_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_mac_row_feeder.sv
// Bench for mac_row_feeder: directed passes, mid-pass reset,
// and randomized passes checked against a stream-level model.
module tb_mac_row_feeder;

    localparam int BW  = 4;
    localparam int COL = 8;
    localparam int CB  = 10;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode_2b = 1'b0;
    logic [CB-1:0] num_act = '0;
    logic [BW-1:0] wgt_data = '0;
    logic          wgt_valid = 1'b0;
    logic          wgt_ready;
    logic [BW-1:0] act_data = '0;
    logic          act_valid = 1'b0;
    logic          act_ready;
    logic [BW-1:0] in_w;
    logic [1:0]    inst_w;
    logic          busy;
    logic          done;

    mac_row_feeder #(
        .bw(BW), .col(COL), .cnt_bw(CB), .gap(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mode_2b(mode_2b), .num_act(num_act),
        .wgt_data(wgt_data), .wgt_valid(wgt_valid),
        .wgt_ready(wgt_ready),
        .act_data(act_data), .act_valid(act_valid),
        .act_ready(act_ready),
        .in_w(in_w), .inst_w(inst_w),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference streams for the current pass
    logic [BW-1:0] wl [16];
    logic [BW-1:0] al [1024];
    bit            cur_m;

    // Monitor state
    bit            mon_en = 1'b0;
    int            cyc = 0;
    int            n01, n10, seq_err, hold_err, bad11, badrdy;
    int            n_done, zrun, gap_run, first10, done_zrun;
    int            busy_at_done, busy_pre, busy_q;
    int            t_f01, t_l01, t_f10, t_l10;
    logic [BW-1:0] last_data = '0;
    logic [BW-1:0] exp_d;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (inst_w == 2'b11) bad11++;
            if (wgt_ready && act_ready) badrdy++;
            if (!busy && (wgt_ready || act_ready)) badrdy++;
            if (done) begin
                n_done++;
                done_zrun    = zrun;
                busy_at_done = int'(busy);
                busy_pre     = busy_q;
            end
            if (inst_w == 2'b01) begin
                if (n01 == 0) t_f01 = cyc;
                t_l01 = cyc;
                if (n01 >= 16 || in_w !== wl[n01 % 16]) seq_err++;
                last_data = in_w;
                n01++;
                zrun = 0;
            end else if (inst_w == 2'b10) begin
                if (n10 == 0) begin
                    t_f10   = cyc;
                    gap_run = zrun;
                    first10 = int'(in_w);
                end
                t_l10 = cyc;
                exp_d = al[n10 % 1024];
                if (cur_m) exp_d = exp_d & 4'h3;
                if (n10 >= 1024 || in_w !== exp_d) seq_err++;
                last_data = in_w;
                n10++;
                zrun = 0;
            end else begin
                if (in_w !== last_data) hold_err++;
                zrun++;
            end
            busy_q = int'(busy);
        end
    end

    // wp/ap: 0 always valid, 1 toggling (weights), 2 random
    // dir: 0 random data, 1 counting data, 2 acts all 4'hE
    task automatic run_pass(input bit m, input int num,
                            input int wp, input int ap,
                            input int dir, input bit sie);
        int wi, ai, tgt, k;
        bit pw, pa, tog, did;
        tgt = COL * (m ? 2 : 1);
        for (int i = 0; i < 16; i++)
            wl[i] = (dir == 1) ? 4'(i + 1) : 4'($urandom);
        for (int i = 0; i < num; i++)
            al[i] = (dir == 1) ? 4'(9 + i)
                  : (dir == 2) ? 4'hE : 4'($urandom);
        @(negedge clk); #1;
        cur_m = m;
        n01 = 0; n10 = 0; seq_err = 0; hold_err = 0;
        bad11 = 0; badrdy = 0; n_done = 0;
        gap_run = -1; first10 = -1; done_zrun = -1;
        busy_at_done = -1; busy_pre = -1;
        start = 1'b1;
        mode_2b = m;
        num_act = CB'(num);
        wgt_valid = 1'b0;
        act_valid = 1'b0;
        wi = 0; ai = 0; pw = 0; pa = 0;
        tog = 0; did = 0; k = 0;
        while (n_done == 0 && k < 3000) begin
            @(negedge clk); #1;
            k++;
            if (pw) wi++;
            if (pa) ai++;
            start = 1'b0;
            mode_2b = 1'($urandom);
            num_act = CB'($urandom);
            if (sie && ai == 1 && !did) begin
                start = 1'b1;
                did = 1;
            end
            tog = ~tog;
            wgt_valid = (wi < tgt) && (wp == 0 || (wp == 1 && tog)
                      || (wp == 2 && $urandom_range(3, 0) != 0));
            wgt_data = wl[wi % 16];
            act_valid = (ai < num) && (ap == 0
                      || (ap == 2 && $urandom_range(3, 0) != 0));
            act_data = al[ai % 1024];
            pw = wgt_valid && wgt_ready;
            pa = act_valid && act_ready;
        end
        wgt_valid = 1'b0;
        act_valid = 1'b0;
        chk("pass_finished", int'(n_done != 0), 1);
        repeat (2) @(negedge clk);
        #1;
        chk("n_load", n01, tgt);
        chk("n_exec", n10, num);
        chk("data_seq", seq_err, 0);
        chk("in_w_hold", hold_err, 0);
        chk("inst_11", bad11, 0);
        chk("ready_rule", badrdy, 0);
        chk("done_pulses", n_done, 1);
        chk("busy_at_done", busy_at_done, 0);
        chk("busy_before_done", busy_pre, 1);
        // Idle row cycles before done: col+1 after the last act;
        // with no acts, also the gap tail after the last weight.
        chk("flush_len", done_zrun,
            (num == 0) ? (GAP - 1) + (COL + 1) : COL + 1);
        if (num != 0) chk("gap_min", int'(gap_run >= GAP), 1);
    endtask

    int dcnt;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_w", int'(in_w), 0);
        chk("rst_inst_w", int'(inst_w), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wgt_ready", int'(wgt_ready), 0);
        chk("rst_act_ready", int'(act_ready), 0);
        #1;
        reset = 1'b0;
        last_data = '0;
        zrun = 0;
        busy_q = 0;
        mon_en = 1'b1;

        // Back-to-back mode 0, weights 1..8, acts 9..12
        run_pass(0, 4, 0, 0, 1, 0);
        chk("t1_wgt_span", t_l01 - t_f01 + 1, COL);
        chk("t1_gap_run", gap_run, GAP);
        chk("t1_act_span", t_l10 - t_f10 + 1, 4);
        chk("t1_first_act", first10, 9);

        // Mode 1: 16 weights, acts 4'hE masked to 4'h2
        run_pass(1, 3, 0, 0, 2, 0);
        chk("t2_mask", first10, 2);

        // Toggling weight valid
        run_pass(0, 5, 1, 0, 0, 0);
        chk("t3_wgt_span", t_l01 - t_f01 + 1, 2 * COL - 1);

        // No activations
        run_pass(0, 0, 0, 0, 0, 0);

        // start pulsed during EXEC is ignored
        run_pass(0, 6, 0, 0, 0, 1);

        // Reset during LOAD
        mon_en = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; mode_2b = 1'b0; num_act = CB'(4);
        @(negedge clk); #1;
        start = 1'b0; wgt_valid = 1'b1; wgt_data = 4'h5;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_load", int'(inst_w), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_inst_w", int'(inst_w), 0);
        chk("mid_rst_in_w", int'(in_w), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_wgt_ready", int'(wgt_ready), 0);
        chk("mid_rst_act_ready", int'(act_ready), 0);
        #1;
        reset = 1'b0;
        wgt_valid = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("mid_rst_quiet", dcnt, 0);
        last_data = '0;
        zrun = 0;
        mon_en = 1'b1;

        // Full-width activation count
        run_pass(0, (1 << CB) - 1, 0, 0, 0, 0);

        for (int p = 0; p < 1000; p++)
            run_pass(1'($urandom), $urandom_range(12, 0),
                     2, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
